// File: rtl/rx_block_assembler_pkg.sv
// Shared 128b/130b receive constants: sync headers, block types, ordered-set
// symbol-0 values and os_type encodings (also used by the LTSSM RX decoder).
package rx_block_assembler_pkg;

  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_OS   = 2'b01;

  localparam logic [1:0] BLK_DATA    = 2'd0;
  localparam logic [1:0] BLK_OS      = 2'd1;
  localparam logic [1:0] BLK_INVALID = 2'd2;

  localparam logic [7:0] OS_SYM_TS1   = 8'h1E;
  localparam logic [7:0] OS_SYM_TS2   = 8'h2D;
  localparam logic [7:0] OS_SYM_SKP   = 8'hAA;
  localparam logic [7:0] OS_SYM_EIEOS = 8'h00;
  localparam logic [7:0] OS_SYM_EIOS  = 8'h66;
  localparam logic [7:0] OS_SYM_SDS   = 8'hE1;

  typedef enum logic [2:0] {
    OS_NONE    = 3'd0,
    OS_TS1     = 3'd1,
    OS_TS2     = 3'd2,
    OS_SKP     = 3'd3,
    OS_EIEOS   = 3'd4,
    OS_EIOS    = 3'd5,
    OS_SDS     = 3'd6,
    OS_UNKNOWN = 3'd7
  } os_type_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_e;

  function automatic logic [1:0] block_type_of(input logic [1:0] sh);
    if (sh == SH_DATA)    return BLK_DATA;
    else if (sh == SH_OS) return BLK_OS;
    else                  return BLK_INVALID;
  endfunction

endpackage

// File: rtl/rx_os_classifier.sv
// Combinational ordered-set classifier: maps symbol 0 of an OS block to os_type.
module rx_os_classifier
  import rx_block_assembler_pkg::*;
(
  input  logic [7:0] symbol0,
  output logic [2:0] os_type
);

  always_comb begin
    os_type = OS_UNKNOWN;
    case (symbol0)
      OS_SYM_TS1:   os_type = OS_TS1;
      OS_SYM_TS2:   os_type = OS_TS2;
      OS_SYM_SKP:   os_type = OS_SKP;
      OS_SYM_EIEOS: os_type = OS_EIEOS;
      OS_SYM_EIOS:  os_type = OS_EIOS;
      OS_SYM_SDS:   os_type = OS_SDS;
      default:      os_type = OS_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/rx_block_assembler.sv
// Gathers descrambled 8/16/32-bit PIPE beats into 16-symbol 128b/130b blocks.
// Define RX_BLOCK_OS_DECODE_EN to classify ordered sets on out_os_type.
module rx_block_assembler
  import rx_block_assembler_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int MAX_W       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_start_block,
  input  logic [1:0]               in_sync_header,
  input  logic [MAX_W-1:0]         in_data,
  input  logic [MAX_W/8-1:0]       in_datak,
  input  logic [5:0]               pipe_width,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BLOCK_BYTES*8-1:0] out_block,
  output logic [1:0]               out_block_type,
  output logic [2:0]               out_os_type,
  output logic                     align_err,
  output logic                     overflow
);

  asm_state_e               state, state_n;
  logic [3:0]               cnt, cnt_n;
  logic [1:0]               sh, sh_n;
  logic [BLOCK_BYTES*8-1:0] blk, blk_n;

  logic [2:0] bpb;
  logic       beat;
  logic       write_en;
  logic [3:0] base;
  logic [3:0] idx;
  logic [4:0] sum;
  logic       complete;
  logic       align_n;
  logic [1:0] type_n;
  logic [2:0] os_n;

  // K flags have no meaning in 128b/130b mode
  logic unused_datak;
  assign unused_datak = ^in_datak;

  always_comb begin
    bpb = 3'd0;
    case (pipe_width)
      6'd8:    bpb = 3'd1;
      6'd16:   bpb = 3'd2;
      6'd32:   bpb = 3'd4;
      default: bpb = 3'd0;
    endcase
  end

  assign beat = in_valid && (bpb != 3'd0);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sh_n     = sh;
    blk_n    = blk;
    base     = cnt;
    write_en = 1'b0;
    align_n  = 1'b0;
    complete = 1'b0;
    idx      = 4'd0;
    sum      = 5'd0;

    if (beat) begin
      case (state)
        ST_IDLE: begin
          if (in_start_block) begin
            sh_n     = in_sync_header;
            base     = 4'd0;
            write_en = 1'b1;
            state_n  = ST_COLLECT;
          end else begin
            align_n = 1'b1;
          end
        end
        ST_COLLECT: begin
          // a restart always lands mid-block here, since cnt==0 means IDLE
          if (in_start_block) begin
            align_n = 1'b1;
            sh_n    = in_sync_header;
            base    = 4'd0;
          end
          write_en = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end

    if (write_en) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < bpb) begin
          idx = base + 4'(i);
          blk_n[{idx, 3'b000} +: 8] = in_data[i*8 +: 8];
        end
      end
      sum = {1'b0, base} + {2'b00, bpb};
      if (sum == 5'd16) begin
        complete = 1'b1;
        cnt_n    = 4'd0;
        state_n  = ST_IDLE;
      end else begin
        cnt_n = sum[3:0];
      end
    end
  end

  assign type_n = block_type_of(sh_n);

`ifdef RX_BLOCK_OS_DECODE_EN
  logic [2:0] os_class;

  rx_os_classifier u_os_classifier (
    .symbol0 (blk_n[7:0]),
    .os_type (os_class)
  );

  assign os_n = (type_n == BLK_OS) ? os_class : 3'(OS_NONE);
`else
  assign os_n = 3'(OS_NONE);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      sh    <= 2'b00;
      blk   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      blk   <= blk_n;
    end
  end

  // Held block is never overwritten while the consumer is stalling
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid      <= 1'b0;
      out_block      <= '0;
      out_block_type <= 2'd0;
      out_os_type    <= 3'd0;
      align_err      <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      align_err <= align_n;
      overflow  <= 1'b0;
      if (complete) begin
        if (!out_valid || out_ready) begin
          out_valid      <= 1'b1;
          out_block      <= blk_n;
          out_block_type <= type_n;
          out_os_type    <= os_n;
        end else begin
          overflow <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_block_assembler.sv
// Directed self-checking bench for rx_block_assembler; expected values are
// hand-computed from the block format.
module tb_rx_block_assembler;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_start_block;
  logic [1:0]   in_sync_header;
  logic [31:0]  in_data;
  logic [3:0]   in_datak;
  logic [5:0]   pipe_width;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic [1:0]   out_block_type;
  logic [2:0]   out_os_type;
  logic         align_err;
  logic         overflow;

  int checks = 0;
  int errors = 0;

`ifdef RX_BLOCK_OS_DECODE_EN
  localparam bit OS_EN = 1'b1;
`else
  localparam bit OS_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  rx_block_assembler dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_start_block (in_start_block),
    .in_sync_header (in_sync_header),
    .in_data        (in_data),
    .in_datak       (in_datak),
    .pipe_width     (pipe_width),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_block      (out_block),
    .out_block_type (out_block_type),
    .out_os_type    (out_os_type),
    .align_err      (align_err),
    .overflow       (overflow)
  );

  function automatic logic [2:0] osExp(input logic [2:0] v);
    return OS_EN ? v : 3'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [1:0] sh,
                               input logic [31:0] data, input logic [5:0] width);
    in_valid       = 1'b1;
    in_start_block = start;
    in_sync_header = sh;
    in_data        = data;
    pipe_width     = width;
    @(posedge clk);
    #1;
    in_valid       = 1'b0;
    in_start_block = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBlock32(input logic [1:0] sh, input logic [127:0] blk);
    for (int i = 0; i < 4; i++)
      applyStimulus(i == 0, sh, blk[i*32 +: 32], 6'd32);
  endtask

  localparam logic [127:0] BLK_T1   = 128'hFFEEDDCC_BBAA9988_77665544_0000001E;
  localparam logic [127:0] BLK_SEQ  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] BLK_A    = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] BLK_B    = 128'h55555555_66666666_77777777_0000002D;
  localparam logic [127:0] BLK_BAD  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] BLK_C    = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
  localparam logic [127:0] BLK_EIOS = 128'h66666666_66666666_66666666_66666666;

  initial begin
    reset          = 1'b0;
    in_valid       = 1'b0;
    in_start_block = 1'b0;
    in_sync_header = 2'b00;
    in_data        = 32'h0;
    in_datak       = 4'h0;
    pipe_width     = 6'd32;
    out_ready      = 1'b1;
    repeat (3) idleCycle();

    checkOutput("rst_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_block", out_block, 128'd0);
    checkOutput("rst_type", 128'(out_block_type), 128'd0);
    checkOutput("rst_os", 128'(out_os_type), 128'd0);
    checkOutput("rst_align", 128'(align_err), 128'd0);
    checkOutput("rst_ovf", 128'(overflow), 128'd0);
    reset = 1'b1;
    idleCycle();

    // Width 32 TS1 ordered set
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 0, 2'b01, BLK_T1[i*32 +: 32], 6'd32);
      if (i == 2) checkOutput("ts1_early_valid", 128'(out_valid), 128'd0);
    end
    checkOutput("ts1_valid", 128'(out_valid), 128'd1);
    checkOutput("ts1_type", 128'(out_block_type), 128'd1);
    checkOutput("ts1_os", 128'(out_os_type), 128'(osExp(3'd1)));
    checkOutput("ts1_sym0", 128'(out_block[7:0]), 128'h1E);
    checkOutput("ts1_block", out_block, BLK_T1);
    idleCycle();
    checkOutput("ts1_consumed", 128'(out_valid), 128'd0);

    // Width 8 data block, 16 beats
    for (int i = 0; i < 16; i++)
      applyStimulus(i == 0, 2'b10, 32'(i), 6'd8);
    checkOutput("w8_valid", 128'(out_valid), 128'd1);
    checkOutput("w8_block", out_block, BLK_SEQ);
    checkOutput("w8_type", 128'(out_block_type), 128'd0);
    checkOutput("w8_os", 128'(out_os_type), 128'd0);
    idleCycle();

    // Width 16 restart on beat 3
    applyStimulus(1'b1, 2'b10, 32'h0000AAAA, 6'd16);
    applyStimulus(1'b0, 2'b10, 32'h0000BBBB, 6'd16);
    applyStimulus(1'b1, 2'b10, 32'h00000100, 6'd16);
    checkOutput("w16_align", 128'(align_err), 128'd1);
    checkOutput("w16_no_out", 128'(out_valid), 128'd0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b0, 2'b10, {16'h0, 8'(2*i+1), 8'(2*i)}, 6'd16);
      if (i == 1) checkOutput("w16_align_clear", 128'(align_err), 128'd0);
    end
    checkOutput("w16_valid", 128'(out_valid), 128'd1);
    checkOutput("w16_block", out_block, BLK_SEQ);
    idleCycle();

    // Overflow while output held
    out_ready = 1'b0;
    sendBlock32(2'b10, BLK_A);
    checkOutput("ovf_first_valid", 128'(out_valid), 128'd1);
    sendBlock32(2'b01, BLK_B);
    checkOutput("ovf_pulse", 128'(overflow), 128'd1);
    checkOutput("ovf_held_block", out_block, BLK_A);
    checkOutput("ovf_held_type", 128'(out_block_type), 128'd0);
    checkOutput("ovf_held_valid", 128'(out_valid), 128'd1);
    idleCycle();
    checkOutput("ovf_pulse_end", 128'(overflow), 128'd0);
    out_ready = 1'b1;
    idleCycle();
    checkOutput("ovf_drained", 128'(out_valid), 128'd0);

    // Invalid sync header
    sendBlock32(2'b11, BLK_BAD);
    checkOutput("bad_sh_type", 128'(out_block_type), 128'd2);
    checkOutput("bad_sh_os", 128'(out_os_type), 128'd0);
    checkOutput("bad_sh_block", out_block, BLK_BAD);
    idleCycle();

    // Beat outside a block, and an unsupported width that must be ignored
    applyStimulus(1'b0, 2'b10, 32'h12345678, 6'd32);
    checkOutput("idle_align", 128'(align_err), 128'd1);
    checkOutput("idle_no_out", 128'(out_valid), 128'd0);
    applyStimulus(1'b0, 2'b10, 32'h12345678, 6'd24);
    checkOutput("bad_width_ignored", 128'(align_err), 128'd0);

    // Reset mid-block with a held output
    out_ready = 1'b0;
    sendBlock32(2'b10, BLK_C);
    checkOutput("pre_rst_valid", 128'(out_valid), 128'd1);
    applyStimulus(1'b1, 2'b01, 32'h99999999, 6'd32);
    applyStimulus(1'b0, 2'b01, 32'h88888888, 6'd32);
    reset = 1'b0;
    idleCycle();
    checkOutput("mid_rst_valid", 128'(out_valid), 128'd0);
    checkOutput("mid_rst_block", out_block, 128'd0);
    checkOutput("mid_rst_ovf", 128'(overflow), 128'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    sendBlock32(2'b01, BLK_EIOS);
    checkOutput("post_rst_valid", 128'(out_valid), 128'd1);
    checkOutput("post_rst_block", out_block, BLK_EIOS);
    checkOutput("post_rst_os", 128'(out_os_type), 128'(osExp(3'd5)));
    checkOutput("post_rst_align", 128'(align_err), 128'd0);
    idleCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
